// File: rtl/modport_regfile.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// modport_regfile
//
// Register file with two combinational read ports and one clocked write port.
// Register 0 always reads as zero. An asynchronous, active-high reset clears
// every register. While reset is high, writes are blocked and both read ports
// return zero.
//
// Parameters
//   DATA_W        register width in bits (default 32)
//   ADDR_W        address width; there are 2**ADDR_W registers (default 5)
//
// Ports
//   clk           rising-edge clock for writes
//   reset         asynchronous active-high clear of all registers
//   ReadRegister1 read port 1 address
//   ReadRegister2 read port 2 address
//   WriteRegister write port address
//   WriteData     write port data
//   RegWrite      write enable, active high
//   ReadData1     contents of register ReadRegister1 (combinational)
//   ReadData2     contents of register ReadRegister2 (combinational)
// -----------------------------------------------------------------------------
module modport_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  input  logic [ADDR_W-1:0] WriteRegister,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              RegWrite,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];

  // Writes to address 0 are dropped so that entry stays at its reset value;
  // the read muxes also force zero for address 0, so register 0 reads zero
  // regardless of what the storage holds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (RegWrite && (WriteRegister != '0)) begin
      regs[WriteRegister] <= WriteData;
    end
  end

  // No write-to-read bypass: a read of the address being written returns the
  // old value until the write edge has occurred. Reset gating makes the
  // outputs zero for the whole time reset is held, not just after it acts.
  always_comb begin
    ReadData1 = '0;
    if (!reset && (ReadRegister1 != '0)) begin
      ReadData1 = regs[ReadRegister1];
    end
  end

  always_comb begin
    ReadData2 = '0;
    if (!reset && (ReadRegister2 != '0)) begin
      ReadData2 = regs[ReadRegister2];
    end
  end

endmodule

// File: tb/tb_modport_regfile.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_modport_regfile
//
// Directed and randomized bench for modport_regfile. The stimulus process
// pushes expected read data (from an array model of the register file) into
// a scoreboard queue and signals a read request; a monitor process pops and
// compares against both read ports.
// -----------------------------------------------------------------------------
module tb_modport_regfile;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] ReadRegister1;
  logic [ADDR_W-1:0] ReadRegister2;
  logic [ADDR_W-1:0] WriteRegister;
  logic [DATA_W-1:0] WriteData;
  logic              RegWrite;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;

  modport_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .RegWrite      (RegWrite),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2)
  );

  always #5 clk = ~clk;

  typedef struct {
    string             name;
    logic [DATA_W-1:0] e1;
    logic [DATA_W-1:0] e2;
  } exp_t;

  exp_t sb[$];
  event chk_ev;
  int   checks = 0;
  int   errors = 0;

  // Reference model: plain array of register contents plus a reset flag.
  logic [DATA_W-1:0] model [32];
  bit                model_rst;

  function automatic logic [DATA_W-1:0] ref_rd(input logic [ADDR_W-1:0] a);
    if (model_rst || a == 0) return '0;
    return model[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = '0;
  endtask

  // Present read addresses, queue the expected data, and let the monitor
  // sample 1 ns later (well away from any clock edge).
  task automatic check_read(input string name, input logic [ADDR_W-1:0] a1,
                            input logic [ADDR_W-1:0] a2);
    exp_t e;
    ReadRegister1 = a1;
    ReadRegister2 = a2;
    e.name = name;
    e.e1   = ref_rd(a1);
    e.e2   = ref_rd(a2);
    sb.push_back(e);
    #1;
    ->chk_ev;
    #1;
  endtask

  // One write cycle: drive at the falling edge, commit at the rising edge.
  task automatic write_edge(input logic we, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d);
    @(negedge clk);
    RegWrite      = we;
    WriteRegister = a;
    WriteData     = d;
    @(posedge clk);
    if (we && !model_rst && a != 0) model[a] = d;
    #1;
    RegWrite = 1'b0;
  endtask

  // Mid-cycle asynchronous reset, with a write attempt across an edge while
  // reset is held, then release at a falling edge.
  task automatic reset_pulse(input logic [ADDR_W-1:0] a);
    #2;
    reset     = 1'b1;
    model_rst = 1'b1;
    model_clear();
    check_read("rst_async", a, ~a);
    RegWrite      = 1'b1;
    WriteRegister = a;
    WriteData     = $urandom;
    @(posedge clk);
    #1;
    check_read("rst_wr_blocked", a, a);
    @(negedge clk);
    reset     = 1'b0;
    model_rst = 1'b0;
    RegWrite  = 1'b0;
    #1;
    check_read("rst_after_release", a, 5'd0);
  endtask

  // Monitor: compare both read ports against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(chk_ev);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty: read sampled with no expectation queued");
      end else begin
        e = sb.pop_front();
        checks++;
        if (ReadData1 !== e.e1) begin
          errors++;
          $display("FAIL %s port1: addr=%0d got=%h expected=%h",
                   e.name, ReadRegister1, ReadData1, e.e1);
        end
        checks++;
        if (ReadData2 !== e.e2) begin
          errors++;
          $display("FAIL %s port2: addr=%0d got=%h expected=%h",
                   e.name, ReadRegister2, ReadData2, e.e2);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [ADDR_W-1:0] a1, a2, wa;
    logic [DATA_W-1:0] wd;
    int                op;

    reset         = 1'b1;
    model_rst     = 1'b1;
    RegWrite      = 1'b0;
    WriteRegister = '0;
    WriteData     = '0;
    ReadRegister1 = '0;
    ReadRegister2 = '0;
    model_clear();

    // Reset state.
    #2;
    check_read("reset_state", 5'd5, 5'd31);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset     = 1'b0;
    model_rst = 1'b0;
    #1;
    check_read("post_reset", 5'd5, 5'd0);

    // Reset clears between edges without a clock edge.
    write_edge(1'b1, 5'd5, 32'hDEADBEEF);
    check_read("wr5", 5'd5, 5'd5);
    #2;
    reset     = 1'b1;
    model_rst = 1'b1;
    model_clear();
    check_read("rst_clear_no_edge", 5'd5, 5'd5);

    // First write after reset release lands on the first rising edge.
    @(negedge clk);
    reset         = 1'b0;
    model_rst     = 1'b0;
    RegWrite      = 1'b1;
    WriteRegister = 5'd5;
    WriteData     = 32'h0BADF00D;
    @(posedge clk);
    model[5] = 32'h0BADF00D;
    #1;
    RegWrite = 1'b0;
    check_read("first_wr_after_rst", 5'd5, 5'd5);

    // Basic write/read on both ports.
    write_edge(1'b1, 5'd7, 32'h12345678);
    check_read("basic_rw", 5'd7, 5'd7);

    // Register 0 hardwired to zero.
    write_edge(1'b1, 5'd0, 32'hFFFFFFFF);
    check_read("reg0_zero", 5'd0, 5'd0);

    // Write enable low.
    write_edge(1'b1, 5'd3, 32'hA5A5A5A5);
    write_edge(1'b0, 5'd3, 32'h11111111);
    check_read("we_low", 5'd3, 5'd3);

    // Dual read of different registers.
    write_edge(1'b1, 5'd31, 32'hFFFFFFFF);
    write_edge(1'b1, 5'd1, 32'h00000001);
    check_read("dual_read", 5'd31, 5'd1);

    // Read-during-write, no bypass.
    write_edge(1'b1, 5'd9, 32'h00000000);
    @(negedge clk);
    RegWrite      = 1'b1;
    WriteRegister = 5'd9;
    WriteData     = 32'hCAFEF00D;
    check_read("rdw_before", 5'd9, 5'd9);
    @(posedge clk);
    model[9] = 32'hCAFEF00D;
    #1;
    RegWrite = 1'b0;
    check_read("rdw_after", 5'd9, 5'd9);

    // Write-port activity between edges that is withdrawn before the edge.
    @(negedge clk);
    RegWrite      = 1'b1;
    WriteRegister = 5'd3;
    WriteData     = 32'h99999999;
    #2;
    RegWrite = 1'b0;
    @(posedge clk);
    #1;
    check_read("between_edges", 5'd3, 5'd7);

    // Data changed between edges: only the value present at the edge is kept.
    @(negedge clk);
    RegWrite      = 1'b1;
    WriteRegister = 5'd12;
    WriteData     = 32'h11112222;
    #2;
    WriteData     = 32'h33334444;
    @(posedge clk);
    model[12] = 32'h33334444;
    #1;
    RegWrite = 1'b0;
    check_read("edge_sampled", 5'd12, 5'd12);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 24);
      if (op == 0) begin
        reset_pulse(5'($urandom_range(1, 31)));
      end else begin
        wa = 5'($urandom);
        case ($urandom_range(0, 7))
          0:       wd = 32'hFFFFFFFF;
          1:       wd = 32'h00000000;
          default: wd = $urandom;
        endcase
        write_edge(($urandom_range(0, 3) != 0), wa, wd);
        a1 = ($urandom_range(0, 1) == 0) ? wa : 5'($urandom);
        a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom);
        check_read("rand", a1, a2);
      end
    end

    // Every queued expectation must have been consumed by the monitor.
    for (int k = 0; k < 10 && sb.size() != 0; k++) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
